// File: rtl/pending_enc16_4.sv
// pending_enc16_4: sticky 16-source pending vector drained by a round-robin 16->4 encoder over valid/ready
module pending_enc16_4 (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] req,
    input  logic        en,
    input  logic        ready_in,
    output logic        valid_out,
    output logic [3:0]  idx_out,
    output logic [15:0] pending,
    output logic        merged
);
    localparam logic [0:0] S_EMPTY = 1'b0;
    localparam logic [0:0] S_FULL  = 1'b1;

    logic [0:0]  r_state;
    logic [3:0]  r_idx;
    logic [3:0]  r_ptr;
    logic [15:0] r_pending;
    logic        r_merged;

    logic        w_load;
    logic        w_any;
    logic        w_grant;
    logic [3:0]  w_off;
    logic [3:0]  w_sel;
    logic [15:0] w_set;
    logic [15:0] w_clr;

    assign w_load  = (r_state == S_EMPTY) || ready_in;
    assign w_any   = |r_pending;
    assign w_grant = w_load && w_any;
    assign w_sel   = r_ptr + w_off;
    assign w_set   = en ? req : 16'h0000;
    assign w_clr   = w_grant ? (16'h0001 << w_sel) : 16'h0000;

    // distance from ptr to the first pending bit, scanning upward with mod-16 wrap
    always_comb begin
        w_off = 4'd0;
        for (int i = 15; i >= 0; i--)
            if (r_pending[r_ptr + 4'(i)]) w_off = 4'(i);
    end

    // output slot, rotating pointer, pending vector and merge flag; set wins over the grant clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_EMPTY;
            r_idx     <= 4'd0;
            r_ptr     <= 4'd0;
            r_pending <= 16'h0000;
            r_merged  <= 1'b0;
        end else begin
            if (w_load) r_state <= w_any ? S_FULL : S_EMPTY;
            if (w_grant) begin
                r_idx <= w_sel;
                r_ptr <= w_sel + 4'd1;
            end
            r_pending <= (r_pending & ~w_clr) | w_set;
            r_merged  <= |(w_set & r_pending & ~w_clr);
        end
    end

    assign valid_out = (r_state == S_FULL);
    assign idx_out   = r_idx;
    assign pending   = r_pending;
    assign merged    = r_merged;
endmodule

// File: tb/tb_pending_enc16_4.sv
// tb_pending_enc16_4: directed stimulus, cycle-by-cycle reference model compare plus literal spot checks
module tb_pending_enc16_4;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] req = 16'h0000;
    logic        en = 1'b0;
    logic        ready_in = 1'b0;
    logic        valid_out;
    logic [3:0]  idx_out;
    logic [15:0] pending;
    logic        merged;

    int n_checks = 0;
    int n_fail = 0;

    pending_enc16_4 dut (
        .clk(clk), .reset_n(reset_n), .req(req), .en(en), .ready_in(ready_in),
        .valid_out(valid_out), .idx_out(idx_out), .pending(pending), .merged(merged)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: scan from ptr for the first pending source, one grant per accepted slot
    logic [15:0] m_pend = 16'h0000;
    logic        m_valid = 1'b0;
    int          m_idx = 0;
    int          m_ptr = 0;
    logic        m_merged = 1'b0;

    always @(posedge clk or negedge reset_n) begin
        logic [15:0] clr, set;
        bit found;
        int sel;
        if (!reset_n) begin
            m_pend = 16'h0000; m_valid = 1'b0; m_idx = 0; m_ptr = 0; m_merged = 1'b0;
        end else begin
            clr = 16'h0000;
            found = 0;
            sel = 0;
            if (!m_valid || ready_in) begin
                for (int k = 0; k < 16; k++)
                    if (!found && m_pend[(m_ptr + k) % 16]) begin
                        found = 1;
                        sel = (m_ptr + k) % 16;
                    end
                if (found) begin
                    m_idx = sel;
                    clr[sel] = 1'b1;
                    m_ptr = (sel + 1) % 16;
                end
                m_valid = found;
            end
            set = en ? req : 16'h0000;
            m_merged = |(set & m_pend & ~clr);
            m_pend = (m_pend & ~clr) | set;
        end
    end

    always @(negedge clk) begin
        check("model_valid", 32'(valid_out), 32'(m_valid));
        check("model_pending", 32'(pending), 32'(m_pend));
        check("model_merged", 32'(merged), 32'(m_merged));
        if (m_valid) check("model_idx", 32'(idx_out), 32'(m_idx));
    end

    task automatic cyc(input logic [15:0] r, input logic e, input logic rd);
        req = r; en = e; ready_in = rd;
        @(negedge clk);
    endtask

    task automatic do_reset();
        req = 16'h0000; en = 1'b0; ready_in = 1'b0;
        reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic expect_out(input string name, input logic v, input logic [3:0] i, input logic [15:0] p);
        check({name, "_valid"}, 32'(valid_out), 32'(v));
        if (v) check({name, "_idx"}, 32'(idx_out), 32'(i));
        check({name, "_pending"}, 32'(pending), 32'(p));
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        check("rst_valid", 32'(valid_out), 0);
        check("rst_idx", 32'(idx_out), 0);
        check("rst_pending", 32'(pending), 0);
        check("rst_merged", 32'(merged), 0);
        reset_n = 1'b1;
        repeat (3) cyc(16'h0000, 1'b0, 1'b0);
        expect_out("idle", 1'b0, 4'd0, 16'h0000);
        check("idle_idx", 32'(idx_out), 0);
        check("idle_merged", 32'(merged), 0);

        cyc(16'h0020, 1'b1, 1'b1);
        expect_out("single_cap", 1'b0, 4'd0, 16'h0020);
        cyc(16'h0000, 1'b0, 1'b1);
        expect_out("single_grant", 1'b1, 4'd5, 16'h0000);
        cyc(16'h0000, 1'b0, 1'b1);
        expect_out("single_empty", 1'b0, 4'd0, 16'h0000);

        do_reset();
        cyc(16'h8101, 1'b1, 1'b1);
        expect_out("multi_cap", 1'b0, 4'd0, 16'h8101);
        cyc(16'h0000, 1'b0, 1'b1);
        expect_out("multi_g0", 1'b1, 4'd0, 16'h8100);
        cyc(16'h0000, 1'b0, 1'b1);
        expect_out("multi_g8", 1'b1, 4'd8, 16'h8000);
        cyc(16'h0000, 1'b0, 1'b1);
        expect_out("multi_g15", 1'b1, 4'd15, 16'h0000);
        cyc(16'h0003, 1'b1, 1'b1);
        expect_out("wrap_cap", 1'b0, 4'd0, 16'h0003);
        cyc(16'h0000, 1'b0, 1'b1);
        expect_out("wrap_g0", 1'b1, 4'd0, 16'h0002);
        cyc(16'h0000, 1'b0, 1'b1);
        expect_out("wrap_g1", 1'b1, 4'd1, 16'h0000);
        cyc(16'h0000, 1'b0, 1'b1);
        expect_out("wrap_empty", 1'b0, 4'd0, 16'h0000);

        cyc(16'h0008, 1'b1, 1'b1);
        cyc(16'h0000, 1'b0, 1'b0);
        expect_out("bp_g3", 1'b1, 4'd3, 16'h0000);
        cyc(16'h0010, 1'b1, 1'b0);
        expect_out("bp_hold1", 1'b1, 4'd3, 16'h0010);
        cyc(16'h0000, 1'b0, 1'b0);
        expect_out("bp_hold2", 1'b1, 4'd3, 16'h0010);
        cyc(16'h0000, 1'b0, 1'b1);
        expect_out("bp_g4", 1'b1, 4'd4, 16'h0000);
        cyc(16'h0000, 1'b0, 1'b1);
        expect_out("bp_empty", 1'b0, 4'd0, 16'h0000);

        cyc(16'h0004, 1'b1, 1'b1);
        expect_out("sc_cap", 1'b0, 4'd0, 16'h0004);
        cyc(16'h0004, 1'b1, 1'b1);
        expect_out("sc_grant", 1'b1, 4'd2, 16'h0004);
        check("sc_merged", 32'(merged), 0);
        cyc(16'h0004, 1'b1, 1'b0);
        check("merge_pulse", 32'(merged), 1);
        expect_out("merge_hold", 1'b1, 4'd2, 16'h0004);
        cyc(16'h0000, 1'b0, 1'b0);
        check("merge_end", 32'(merged), 0);
        cyc(16'h0000, 1'b0, 1'b1);
        expect_out("sc_g2", 1'b1, 4'd2, 16'h0000);
        cyc(16'h0000, 1'b0, 1'b1);
        expect_out("sc_empty", 1'b0, 4'd0, 16'h0000);

        do_reset();
        cyc(16'hFFFF, 1'b1, 1'b1);
        cyc(16'h0000, 1'b0, 1'b1);
        expect_out("full_g0", 1'b1, 4'd0, 16'hFFFE);
        cyc(16'h0000, 1'b0, 1'b1);
        expect_out("full_g1", 1'b1, 4'd1, 16'hFFFC);
        #2 reset_n = 1'b0;
        #1;
        check("async_valid", 32'(valid_out), 0);
        check("async_idx", 32'(idx_out), 0);
        check("async_pending", 32'(pending), 0);
        check("async_merged", 32'(merged), 0);
        @(negedge clk);
        reset_n = 1'b1;
        cyc(16'hFFFF, 1'b1, 1'b1);
        for (int i = 0; i < 16; i++) begin
            cyc(16'h0000, 1'b0, 1'b1);
            check("drain_valid", 32'(valid_out), 1);
            check("drain_idx", 32'(idx_out), 32'(i));
        end
        cyc(16'h0000, 1'b0, 1'b1);
        expect_out("drain_empty", 1'b0, 4'd0, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
